// File: rtl/fft_bfly_stage_pkg.sv
// Shared types, Q8.8 constants and the twiddle ROM for the radix-2 DIF butterfly stage.
// The twiddle table is indexed by block length N and butterfly index k.
package fft_bfly_stage_pkg;

    typedef logic [15:0] calc_temp_bus_t;
    typedef logic [3:0]  dnum_bus_t;

    localparam logic signed [15:0] ONE         = 16'sh0100;
    localparam logic signed [15:0] RND         = 16'sh0080;
    localparam logic signed [15:0] SAT_MAX     = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN     = 16'sh8000;
    localparam logic signed [15:0] NEG_ONE     = 16'shFF00;
    localparam logic signed [15:0] INV_SQRT2   = 16'sh00B5;
    localparam logic signed [15:0] NEG_ISQRT2  = 16'shFF4B;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } twiddle_t;

    // W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N); entries not listed are W = 1.
    function automatic twiddle_t twiddle_rom(input logic [3:0] n, input logic [2:0] k);
        twiddle_t w;
        w.re = ONE;
        w.im = '0;
        if (n == 4'd4 && k == 3'd1) begin
            w.re = '0;
            w.im = NEG_ONE;
        end else if (n == 4'd8) begin
            case (k)
                3'd1: begin
                    w.re = INV_SQRT2;
                    w.im = NEG_ISQRT2;
                end
                3'd2: begin
                    w.re = '0;
                    w.im = NEG_ONE;
                end
                3'd3: begin
                    w.re = NEG_ISQRT2;
                    w.im = NEG_ISQRT2;
                end
                default: begin
                    w.re = ONE;
                    w.im = '0;
                end
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/fft_bfly_stage_sat_round_q88.sv
// Combinational round-half-up, arithmetic shift and saturate from a wide signed
// value down to 16-bit Q8.8, with a flag raised whenever clipping happens.
module sat_round_q88
    import fft_bfly_stage_pkg::*;
#(
    parameter int IW = 33,
    parameter int SH = 8
) (
    input  logic signed [IW-1:0] din,
    output logic signed [15:0]   dout,
    output logic                 ovf
);

    localparam int EW = IW + 1;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;
    logic [EW-16:0]       hi;

    // One guard bit so the rounding add can never wrap.
    assign ext = {din[IW-1], din};

    generate
        if (SH > 0) begin : g_round
            logic signed [EW-1:0] rnd;
            assign rnd     = ext + (EW'(1) <<< (SH - 1));
            assign shifted = rnd >>> SH;
        end else begin : g_pass
            assign shifted = ext;
        end
    endgenerate

    assign hi = shifted[EW-1:15];

    always_comb begin
        ovf  = !((&hi) || (~|hi));
        dout = shifted[15:0];
        if (ovf) begin
            dout = shifted[EW-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/fft_bfly_stage.sv
// Streaming radix-2 DIF butterfly: pairs x[n] with x[n-D] from the external delay
// line, emits sum and twiddled difference three clocks after the issuing sample.
module fft_bfly_stage
    import fft_bfly_stage_pkg::*;
#(
    parameter int DLY   = 2,
    parameter bit SCALE = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           in_valid,
    input  calc_temp_bus_t in_data,
    input  calc_temp_bus_t dly_data,
    output dnum_bus_t      dnum,
    output logic           out_valid,
    output logic [2:0]     out_idx,
    output calc_temp_bus_t out_sum,
    output calc_temp_bus_t out_diff_re,
    output calc_temp_bus_t out_diff_im,
    output logic           ovf
);

    // Valid-only stream: in_valid qualifies in_data/dly_data on the same edge and
    // out_valid qualifies the result ports for exactly one cycle; there is no ready.

    localparam int             N        = 2 * DLY;
    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_D    = CW'(DLY);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [3:0]     N_CODE   = 4'(N);

    assign dnum = 4'(DLY);

    logic [CW-1:0] cnt;
    logic          issue;
    logic [2:0]    k_issue;

    logic signed [16:0] in_x;
    logic signed [16:0] dly_x;

    logic               s1_valid;
    logic signed [16:0] s1_s;
    logic signed [16:0] s1_d;
    logic [2:0]         s1_k;

    logic               s2_valid;
    logic signed [16:0] s2_s;
    logic signed [32:0] s2_pre;
    logic signed [32:0] s2_pim;
    logic [2:0]         s2_k;

    logic               s3_valid;
    logic signed [15:0] s3_sum;
    logic signed [15:0] s3_re;
    logic signed [15:0] s3_im;
    logic               s3_ovf;
    logic [2:0]         s3_k;

    twiddle_t           tw;
    logic signed [15:0] r_sum;
    logic signed [15:0] r_re;
    logic signed [15:0] r_im;
    logic               v_sum;
    logic               v_re;
    logic               v_im;

    assign in_x    = {in_data[15], in_data};
    assign dly_x   = {dly_data[15], dly_data};
    // clr outranks in_valid: the sample on a clr cycle is neither counted nor issued.
    assign issue   = in_valid && !clr && (cnt >= CNT_D);
    assign k_issue = 3'(cnt - CNT_D);
    assign tw      = twiddle_rom(N_CODE, s1_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_d     <= '0;
            s1_k     <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_s <= dly_x + in_x;
                s1_d <= dly_x - in_x;
                s1_k <= k_issue;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_s     <= '0;
            s2_pre   <= '0;
            s2_pim   <= '0;
            s2_k     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_s   <= s1_s;
                s2_pre <= 33'(s1_d) * 33'(tw.re);
                s2_pim <= 33'(s1_d) * 33'(tw.im);
                s2_k   <= s1_k;
            end
        end
    end

    sat_round_q88 #(.IW(33), .SH(8)) u_sat_re (
        .din  (s2_pre),
        .dout (r_re),
        .ovf  (v_re)
    );

    sat_round_q88 #(.IW(33), .SH(8)) u_sat_im (
        .din  (s2_pim),
        .dout (r_im),
        .ovf  (v_im)
    );

    // With SCALE the sum is halved with rounding and cannot clip; otherwise it saturates.
    sat_round_q88 #(.IW(17), .SH(SCALE ? 1 : 0)) u_sat_sum (
        .din  (s2_s),
        .dout (r_sum),
        .ovf  (v_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_sum   <= '0;
            s3_re    <= '0;
            s3_im    <= '0;
            s3_ovf   <= 1'b0;
            s3_k     <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sum <= r_sum;
                s3_re  <= r_re;
                s3_im  <= r_im;
                s3_ovf <= v_sum || v_re || v_im;
                s3_k   <= s2_k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_sum     <= '0;
            out_diff_re <= '0;
            out_diff_im <= '0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_idx     <= s3_k;
                out_sum     <= s3_sum;
                out_diff_re <= s3_re;
                out_diff_im <= s3_im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (s3_valid && s3_ovf) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Directed bench for fft_bfly_stage: three instances (D=2 saturating, D=2 scaled,
// D=4 saturating) fed from one stream through a clock-counting delay-line model.
module tb_fft_bfly_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0][15:0] hist = '0;
    logic [15:0] dly2;
    logic [15:0] dly4;

    logic [3:0]  dnum [3];
    logic        ov    [3];
    logic [2:0]  idx   [3];
    logic [15:0] sum   [3];
    logic [15:0] dre   [3];
    logic [15:0] dim   [3];
    logic        flg   [3];

    int checks = 0;
    int failures = 0;

    logic [50:0] cap_q0[$];
    logic [50:0] cap_q1[$];
    logic [50:0] cap_q2[$];
    logic [50:0] exp_q[$];

    typedef struct packed {
        logic [1:0]       sel;
        logic [7:0][15:0] x;
        logic [3:0][15:0] esum;
        logic [3:0][15:0] ere;
        logic [3:0][15:0] eim;
        logic             eovf;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    // Delay-line model: counts clocks, hist[0] is the sample taken on the last edge.
    always @(posedge clk) hist <= {hist[2:0], in_data};
    assign dly2 = hist[1];
    assign dly4 = hist[3];

    fft_bfly_stage #(.DLY(2), .SCALE(1'b0)) u_d2s0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .dly_data(dly2), .dnum(dnum[0]), .out_valid(ov[0]), .out_idx(idx[0]),
        .out_sum(sum[0]), .out_diff_re(dre[0]), .out_diff_im(dim[0]), .ovf(flg[0])
    );

    fft_bfly_stage #(.DLY(2), .SCALE(1'b1)) u_d2s1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .dly_data(dly2), .dnum(dnum[1]), .out_valid(ov[1]), .out_idx(idx[1]),
        .out_sum(sum[1]), .out_diff_re(dre[1]), .out_diff_im(dim[1]), .ovf(flg[1])
    );

    fft_bfly_stage #(.DLY(4), .SCALE(1'b0)) u_d4s0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .dly_data(dly4), .dnum(dnum[2]), .out_valid(ov[2]), .out_idx(idx[2]),
        .out_sum(sum[2]), .out_diff_re(dre[2]), .out_diff_im(dim[2]), .ovf(flg[2])
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov[0]) cap_q0.push_back({idx[0], sum[0], dre[0], dim[0]});
            if (ov[1]) cap_q1.push_back({idx[1], sum[1], dre[1], dim[1]});
            if (ov[2]) cap_q2.push_back({idx[2], sum[2], dre[2], dim[2]});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic v, input logic c);
        in_data  = x;
        in_valid = v;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap_q0.delete();
        cap_q1.delete();
        cap_q2.delete();
        exp_q.delete();
    endtask

    // Drains exp_q against the captured results of the selected instance.
    task automatic cmp_queue(input string tag, input int sel);
        logic [50:0] got[$];
        logic [50:0] a;
        logic [50:0] e;
        int          n;
        case (sel)
            0: got = cap_q0;
            1: got = cap_q1;
            default: got = cap_q2;
        endcase
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got.size() > 0) ? got.pop_front() : 'x;
            chk($sformatf("%s_out%0d", tag, n), 64'(a), 64'(e));
            n++;
        end
    endtask

    function automatic vec_t mk4(input logic [1:0] sel,
                                 input logic [15:0] x0, input logic [15:0] x1,
                                 input logic [15:0] x2, input logic [15:0] x3,
                                 input logic [15:0] s0, input logic [15:0] r0, input logic [15:0] i0,
                                 input logic [15:0] s1, input logic [15:0] r1, input logic [15:0] i1,
                                 input logic eovf);
        vec_t v;
        v = '0;
        v.sel = sel;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.esum[0] = s0; v.ere[0] = r0; v.eim[0] = i0;
        v.esum[1] = s1; v.ere[1] = r1; v.eim[1] = i1;
        v.eovf = eovf;
        return v;
    endfunction

    initial begin
        int n;
        int sel;
        logic exp_v;
        int t;

        vecs[0] = mk4(2'd0, 16'h0100, 16'h0200, 16'h0300, 16'h0400,
                      16'h0400, 16'hFE00, 16'h0000, 16'h0600, 16'h0000, 16'h0200, 1'b0);
        vecs[1] = '0;
        vecs[1].sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            vecs[1].x[i]    = 16'h0100;
            vecs[1].esum[i] = 16'h0100;
        end
        vecs[1].ere[0] = 16'h0100; vecs[1].eim[0] = 16'h0000;
        vecs[1].ere[1] = 16'h00B5; vecs[1].eim[1] = 16'hFF4B;
        vecs[1].ere[2] = 16'h0000; vecs[1].eim[2] = 16'hFF00;
        vecs[1].ere[3] = 16'hFF4B; vecs[1].eim[3] = 16'hFF4B;
        vecs[2] = '0;
        vecs[2].sel = 2'd2;
        vecs[2].x[1] = 16'h0100;
        vecs[2].esum[1] = 16'h0100; vecs[2].ere[1] = 16'h00B5; vecs[2].eim[1] = 16'hFF4B;
        vecs[3] = mk4(2'd0, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000,
                      16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        vecs[4] = mk4(2'd1, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000,
                      16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        vecs[5] = mk4(2'd0, 16'h7F00, 16'h7F00, 16'h8100, 16'h8100,
                      16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        vecs[6] = mk4(2'd1, 16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE,
                      16'h0002, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        vecs[7] = mk4(2'd0, 16'h8000, 16'h0000, 16'h8000, 16'h0000,
                      16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);

        // Reset state while rst_n is held low.
        #3;
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_out_sum", 64'(sum[0]), 64'd0);
        chk("rst_ovf", 64'(flg[0]), 64'd0);
        chk("dnum_d2", 64'(dnum[0]), 64'd2);
        chk("dnum_d4", 64'(dnum[2]), 64'd4);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            sel = int'(vecs[i].sel);
            n = (sel == 2) ? 8 : 4;
            for (int j = 0; j < n; j++) send(vecs[i].x[j], 1'b1, 1'b0);
            idle(6);
            for (int k = 0; k < n / 2; k++)
                exp_q.push_back({3'(k), vecs[i].esum[k], vecs[i].ere[k], vecs[i].eim[k]});
            cmp_queue($sformatf("vec%0d", i), sel);
            case (sel)
                0: chk($sformatf("vec%0d_ovf", i), 64'(flg[0]), 64'(vecs[i].eovf));
                1: chk($sformatf("vec%0d_ovf", i), 64'(flg[1]), 64'(vecs[i].eovf));
                default: chk($sformatf("vec%0d_ovf", i), 64'(flg[2]), 64'(vecs[i].eovf));
            endcase
        end

        // Cycle-exact latency and bubble-free streaming of three N=4 blocks.
        do_reset();
        for (int e = 0; e < 18; e++) begin
            if (e < 12) send(16'((e % 4 + 1) * 256), 1'b1, 1'b0);
            else idle(1);
            t = e - 3;
            exp_v = (t >= 0) && (t < 12) && ((t % 4) >= 2);
            chk($sformatf("stream_valid_e%0d", e), 64'(ov[0]), 64'(exp_v));
            if (exp_v) begin
                chk($sformatf("stream_idx_e%0d", e), 64'(idx[0]), 64'((t % 4) - 2));
                chk($sformatf("stream_sum_e%0d", e), 64'(sum[0]),
                    ((t % 4) == 2) ? 64'h0400 : 64'h0600);
            end
        end

        // clr together with in_valid at cnt=1 after a saturating block.
        do_reset();
        send(16'h7F00, 1'b1, 1'b0);
        send(16'h0000, 1'b1, 1'b0);
        send(16'h7F00, 1'b1, 1'b0);
        send(16'h0000, 1'b1, 1'b0);
        idle(6);
        chk("clr_pre_ovf", 64'(flg[0]), 64'd1);
        idle(2);
        chk("clr_ovf_sticky", 64'(flg[0]), 64'd1);
        cap_q0.delete();
        send(16'h0100, 1'b1, 1'b0);
        send(16'h0200, 1'b1, 1'b1);
        chk("clr_ovf_cleared", 64'(flg[0]), 64'd0);
        send(16'h0100, 1'b1, 1'b0);
        send(16'h0200, 1'b1, 1'b0);
        send(16'h0300, 1'b1, 1'b0);
        send(16'h0400, 1'b1, 1'b0);
        idle(6);
        exp_q.push_back({3'd0, 16'h0400, 16'hFE00, 16'h0000});
        exp_q.push_back({3'd1, 16'h0600, 16'h0000, 16'h0200});
        cmp_queue("clr", 0);
        chk("clr_post_ovf", 64'(flg[0]), 64'd0);

        // Asynchronous reset while a saturated result is on the outputs.
        do_reset();
        send(16'h7F00, 1'b1, 1'b0);
        send(16'h0000, 1'b1, 1'b0);
        send(16'h7F00, 1'b1, 1'b0);
        send(16'h0000, 1'b1, 1'b0);
        idle(2);
        chk("midrst_pre_valid", 64'(ov[0]), 64'd1);
        chk("midrst_pre_ovf", 64'(flg[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ov[0]), 64'd0);
        chk("midrst_idx", 64'(idx[0]), 64'd0);
        chk("midrst_sum", 64'(sum[0]), 64'd0);
        chk("midrst_re", 64'(dre[0]), 64'd0);
        chk("midrst_im", 64'(dim[0]), 64'd0);
        chk("midrst_ovf", 64'(flg[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap_q0.delete();
        idle(4);
        chk("midrst_discard", 64'(cap_q0.size()), 64'd0);
        send(16'h0100, 1'b1, 1'b0);
        send(16'h0200, 1'b1, 1'b0);
        send(16'h0300, 1'b1, 1'b0);
        send(16'h0400, 1'b1, 1'b0);
        idle(6);
        exp_q.push_back({3'd0, 16'h0400, 16'hFE00, 16'h0000});
        exp_q.push_back({3'd1, 16'h0600, 16'h0000, 16'h0200});
        cmp_queue("postrst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
